// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_read_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic [2:0]       AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]       AXI_BURST_INCR = 2'b01;
  localparam logic [LEN_W-1:0] LINE_ARLEN     = 8'd7;

  // Latched AR payload of the accepted request
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ar_req_t;

endpackage

// File: rtl/axi_read_arbiter_rr_pick2.sv
// Combinational 2-way round-robin select.
//   req        : request vector, bit N = requester N
//   last_grant : requester that owned the previous transaction
//   grant      : selected requester (valid when any=1)
//   any        : at least one request present
module axi_read_arbiter_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  assign any = |req;

  // A tie goes to whoever did not win last time; otherwise the lone requester.
  assign grant = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel (AR/R) between the instruction cache (requester 0)
// and the data cache (requester 1). One outstanding transaction at a time,
// round-robin on ties, R beats steered back to the owner, sticky protocol error.
//   clk, rst              : clock, synchronous active-high reset
//   s0_* / s1_*           : requester AR request and R beat interfaces
//   m_ar* / m_r*          : AXI master read channel towards the bus
//   err                   : sticky error (bad RID, early or missing RLAST)
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ID_REQ0 = 0,
  parameter int unsigned ID_REQ1 = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rvalid,
  output logic              s0_rlast,
  input  logic              s0_rready,

  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rvalid,
  output logic              s1_rlast,
  input  logic              s1_rready,

  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,

  output logic              err
);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  ar_req_t          req_q, req_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

  logic             pick_grant;
  logic             pick_any;
  logic [ID_W-1:0]  issued_id;
  logic             r_hs;

  axi_read_arbiter_rr_pick2 u_pick (
    .req        ({s1_arvalid, s0_arvalid}),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  assign issued_id = grant_q ? ID_W'(ID_REQ1) : ID_W'(ID_REQ0);

  // AR fields come straight from the latched request so they hold through ADDR
  assign m_arid    = issued_id;
  assign m_araddr  = req_q.addr;
  assign m_arlen   = req_q.len;
  assign m_arsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;
  assign err       = err_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      req_q        <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

  // Next-state, handshakes, R steering and protocol checks
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    s0_arready   = 1'b0;
    s1_arready   = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    s0_rdata     = '0;
    s0_rvalid    = 1'b0;
    s0_rlast     = 1'b0;
    s1_rdata     = '0;
    s1_rvalid    = 1'b0;
    s1_rlast     = 1'b0;
    r_hs         = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_grant;
          s0_arready = ~pick_grant;
          s1_arready = pick_grant;
          req_d      = pick_grant ? '{addr: s1_araddr, len: s1_arlen}
                                  : '{addr: s0_araddr, len: s0_arlen};
          beat_cnt_d = '0;
          state_d    = ARB_ADDR;
        end
      end

      ARB_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = ARB_DATA;
      end

      ARB_DATA: begin
        if (grant_q) begin
          s1_rdata  = m_rdata;
          s1_rvalid = m_rvalid;
          s1_rlast  = m_rlast;
          m_rready  = s1_rready;
        end else begin
          s0_rdata  = m_rdata;
          s0_rvalid = m_rvalid;
          s0_rlast  = m_rlast;
          m_rready  = s0_rready;
        end
        r_hs = m_rvalid & m_rready;
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          // RLAST must coincide exactly with the beat numbered len
          if (m_rid != issued_id) err_d = 1'b1;
          if (m_rlast != (beat_cnt_q == req_q.len)) err_d = 1'b1;
          if (m_rlast) begin
            last_grant_d = grant_q;
            state_d      = ARB_IDLE;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI read channel (AR/R) of the CPU bus interface between two requesters: requester 0 = instruction cache, requester 1 = data cache (each covers cached line fills and uncached single reads).
- Serialises to one outstanding transaction at a time.
- Selects between simultaneous requests by round-robin and steers R-channel beats back to the owner.
- Checks burst length and ID, and flags a sticky protocol error.

Parameters:
- ID_W, 4, width of AXI arid/rid.
- ID_REQ0, 0, arid issued for requester 0.
- ID_REQ1, 1, arid issued for requester 1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high (`RST_ENABLE`).
- s0_araddr  in  32  requester 0 read address.
- s0_arlen  in  8  requester 0 beats minus 1 (7 = line fill, 0 = uncached).
- s0_arvalid  in  1  requester 0 request; held until s0_arready.
- s0_arready  out  1  request accepted (1-cycle pulse).
- s0_rdata  out  32  read beat data.
- s0_rvalid  out  1  beat valid.
- s0_rlast  out  1  final beat.
- s0_rready  in  1  requester 0 ready for beat.
- s1_araddr, s1_arlen, s1_arvalid, s1_arready, s1_rdata, s1_rvalid, s1_rlast, s1_rready: same as s0_*, for requester 1.
- m_arid  out  ID_W  issued ID.
- m_araddr  out  32  issued address.
- m_arlen  out  8  issued length.
- m_arsize  out  3  constant 3'b010.
- m_arburst  out  2  constant 2'b01 (INCR).
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_rid  in  ID_W  R ID.
- m_rdata  in  32  R data.
- m_rlast  in  1  R last.
- m_rvalid  in  1  R valid.
- m_rready  out  1  R ready.
- err  out  1  sticky protocol error.

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: grant (1b), last_grant (1b), addr_r, len_r, beat_cnt (8b), err.
- Reset (synchronous, any state):
  - state=IDLE, grant=0, last_grant=1 (requester 0 wins the first tie), beat_cnt=0, err=0.
  - All valid/ready outputs 0; m_araddr/m_arlen/m_arid = 0.
- IDLE:
  - If exactly one sN_arvalid: grant=N.
  - If both: grant = ~last_grant.
  - sN_arready=1 combinationally in this cycle for the granted requester only. Latch address and length into addr_r/len_r. beat_cnt=0. Next state ADDR.
  - No request: stay in IDLE.
- ADDR:
  - m_arvalid=1; m_araddr=addr_r; m_arlen=len_r; m_arid = ID_REQ0 or ID_REQ1 per grant.
  - Hold all AR fields stable until m_arready. On m_arvalid&m_arready, go to DATA.
- DATA:
  - Combinational steering:
    - sG_rdata = m_rdata; sG_rvalid = m_rvalid; sG_rlast = m_rlast; m_rready = sG_rready.
    - Non-granted requester sees rvalid=0.
  - On each handshake (m_rvalid&m_rready): beat_cnt += 1.
  - Handshake with m_rlast: last_grant=grant, go to IDLE.
- Error checks during DATA (err set, never cleared except by reset; transfer continues regardless):
  - m_rid != issued ID on a handshake.
  - m_rlast=1 with beat_cnt != len_r.
  - Handshake with beat_cnt == len_r and m_rlast=0.
- Latency:
  - Request at cycle N (IDLE) gives m_arvalid at N+1.
  - Minimum one IDLE cycle between the last beat of one burst and the AR of the next. Back-to-back request in the same cycle as rlast is serviced from the following IDLE.
- Outside DATA: m_rready=0, all sN_rvalid=0. Outside ADDR: m_arvalid=0.
- A requester dropping arvalid after acceptance is legal and has no effect.
- Reset mid-transaction: abandon the burst, return to IDLE. The bus slave is reset by the same rst, so no stray beats are expected.

Decomposition:
- defines.vh gains:
  - State encodings ARB_IDLE/ARB_ADDR/ARB_DATA.
  - AXI constants AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01.
  - Line-fill length LINE_ARLEN=8'd7.
- Optional sub-module rr_pick2: combinational 2-way round-robin select (req[1:0], last_grant, outputs grant and any). The rest stays flat.

Test Plan:
- s0 only, araddr=0x1FC0_0020, arlen=7, m_arready same cycle, 8 beats 0xA0..0xA7 → m_araddr=0x1FC0_0020, m_arid=0, s0 receives 8 beats with rlast on 0xA7, s1_rvalid=0 throughout, err=0.
- s0 and s1 request in the same cycle from reset → s0 granted first. While s0's burst runs, s1 holds arvalid; s1 (araddr=0x8000_0100) is issued the cycle after s0's rlast IDLE cycle, with m_arid=1.
- s1 uncached, arlen=0, araddr=0xBFAF_F000, m_arready delayed 3 cycles → m_araddr/m_arlen/m_arid held stable for 4 cycles; single beat 0x1234_5678 with rlast delivered to s1; returns to IDLE.
- s0 rready low for 2 cycles mid-burst → m_rready low for those cycles, beat_cnt not advanced, data order intact.
- Burst arlen=7 but slave asserts rlast on beat 4 → err=1 and stays 1, arbiter returns to IDLE. Next burst with rid=5 ≠ issued ID also keeps err=1.
- rst asserted during DATA after 3 beats → next cycle IDLE, all outputs at reset values, err=0; a subsequent s1 request is granted normally.
